// File: rtl/ysyx_25060173_inst_fetch_if.sv
// Fetch unit bus bundle: next-PC input, imem request/response channels and
// the instruction handshake toward the decoder.
interface ysyx_25060173_inst_fetch_if;
    localparam int unsigned XLEN = 32;

    // next PC from the execute stage
    logic [XLEN-1:0] next_pc;
    logic            next_pc_valid;

    // instruction memory read request (valid/ready)
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;

    // instruction memory read response (valid only)
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            imem_rsp_err;

    // instruction toward the decoder (valid/ready)
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            fetch_fault;

    // fetch unit side
    modport master (
        input  next_pc,
        input  next_pc_valid,
        output imem_req_valid,
        input  imem_req_ready,
        output imem_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  imem_rsp_err,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        output fetch_fault
    );

    // surrounding core / memory side
    modport slave (
        output next_pc,
        output next_pc_valid,
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        output imem_rsp_err,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        input  fetch_fault
    );
endinterface

// File: rtl/ysyx_25060173_inst_fetch.sv
// Instruction fetch unit for the multi-cycle RV32 core: one imem read per
// instruction, result handed to the decoder with its PC. A misaligned
// next_pc or a bus error substitutes an ebreak so the decoder halts the core.
module ysyx_25060173_inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] HALT_INST = 32'h0010_0073
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ysyx_25060173_inst_fetch_if.master    bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            req_valid_q;
    logic            inst_valid_q;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic            fault_q;

    // Fetch sequencer; every output is a register updated on state transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            req_valid_q  <= 1'b1;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            fault_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.next_pc_valid) begin
                        pc <= bus.next_pc;
                        if (bus.next_pc[1:0] == 2'b00) begin
                            state       <= S_REQ;
                            req_valid_q <= 1'b1;
                        end else begin
                            // misaligned target: skip memory, hand over a halt
                            state        <= S_HOLD;
                            inst_valid_q <= 1'b1;
                            inst_q       <= HALT_INST;
                            inst_pc_q    <= bus.next_pc;
                            fault_q      <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    // responses seen here are stale and dropped
                    if (bus.imem_req_ready) begin
                        state       <= S_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        state        <= S_HOLD;
                        inst_valid_q <= 1'b1;
                        inst_pc_q    <= pc;
                        if (bus.imem_rsp_err) begin
                            inst_q  <= HALT_INST;
                            fault_q <= 1'b1;
                        end else begin
                            inst_q  <= bus.imem_rsp_data;
                            fault_q <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.inst_ready) begin
                        state        <= S_IDLE;
                        inst_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    req_valid_q  <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Registered outputs onto the bus
    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_addr      = pc;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.fetch_fault    = fault_q;

endmodule

// File: tb/tb_ysyx_25060173_inst_fetch.sv
// Directed bench for the fetch unit with a small imem responder and a
// scoreboard of expected instructions.
module tb_ysyx_25060173_inst_fetch;
    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] HALT_INST = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    ysyx_25060173_inst_fetch_if ifc ();

    ysyx_25060173_inst_fetch #(
        .RESET_PC  (RESET_PC),
        .HALT_INST (HALT_INST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_valid_cyc = 0;
    exp_t q[$];

    // responder controls written only by the main initial block
    int          stall_cfg = 0;
    int          stall_gen = 0;
    int          stray_gen = 0;
    bit          err_en    = 1'b0;
    logic [31:0] err_addr  = '0;

    // responder state
    int          stall_left = 0;
    int          stall_seen = 0;
    int          stray_seen = 0;
    logic        acc;
    logic [31:0] acc_addr;
    int          req_count = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return a ^ 32'h5A5A_0013;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Accepted request tracking; a reset drops anything in flight
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else begin
            acc      <= ifc.imem_req_valid && ifc.imem_req_ready;
            acc_addr <= ifc.imem_addr;
            if (ifc.imem_req_valid && ifc.imem_req_ready) req_count <= req_count + 1;
        end
    end

    // Memory model: ready with optional stall, response one cycle after acceptance
    always @(negedge clk) begin
        #1;
        if (stall_gen != stall_seen) begin
            stall_left = stall_cfg;
            stall_seen = stall_gen;
        end
        if (!rst_n) begin
            ifc.imem_req_ready = (stall_left == 0);
        end else if (ifc.imem_req_valid && stall_left > 0) begin
            ifc.imem_req_ready = 1'b0;
            stall_left--;
        end else begin
            ifc.imem_req_ready = 1'b1;
        end
        ifc.imem_rsp_valid = acc;
        ifc.imem_rsp_data  = mem_word(acc_addr);
        ifc.imem_rsp_err   = acc && err_en && (acc_addr == err_addr);
        if (stray_gen != stray_seen) begin
            stray_seen = stray_gen;
            if (!acc) begin
                ifc.imem_rsp_valid = 1'b1;
                ifc.imem_rsp_data  = 32'hDEAD_BEEF;
                ifc.imem_rsp_err   = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait for inst_valid, compare against the scoreboard, hold, then accept
    task automatic receive(input int hold);
        exp_t e;
        bit   got;
        got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (ifc.inst_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check("inst_valid_timeout", 32'(ifc.inst_valid), 32'd1);
            return;
        end
        last_valid_cyc = cyc;
        if (q.size() == 0) begin
            check("scoreboard_empty", 32'(q.size()), 32'd1);
            return;
        end
        e = q.pop_front();
        check("inst", ifc.inst, e.inst);
        check("inst_pc", ifc.inst_pc, e.pc);
        check("fetch_fault", 32'(ifc.fetch_fault), 32'(e.fault));
        for (int h = 0; h < hold; h++) begin
            ifc.inst_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", 32'(ifc.inst_valid), 32'd1);
            check("hold_inst", ifc.inst, e.inst);
            check("hold_pc", ifc.inst_pc, e.pc);
        end
        ifc.inst_ready = 1'b1;
        @(negedge clk);
        ifc.inst_ready = 1'b0;
        check("valid_drop", 32'(ifc.inst_valid), 32'd0);
        check("inst_kept", ifc.inst, e.inst);
        check("pc_kept", ifc.inst_pc, e.pc);
    endtask

    // One fetch started from IDLE through next_pc_valid
    task automatic fetch(input logic [31:0] pc, input int stall, input int hold,
                         input bit err, input bit wait_pulse);
        exp_t e;
        bit   aligned;
        int   rc0;
        int   c0;
        aligned = (pc[1:0] == 2'b00);
        e.fault = !aligned || err;
        e.inst  = e.fault ? HALT_INST : mem_word(pc);
        e.pc    = pc;
        q.push_back(e);
        stall_cfg = stall;
        stall_gen++;
        err_en    = err;
        err_addr  = pc;
        rc0 = req_count;
        c0  = cyc;
        ifc.next_pc       = pc;
        ifc.next_pc_valid = 1'b1;
        @(negedge clk);
        ifc.next_pc_valid = 1'b0;
        if (aligned) begin
            check("req_issue", 32'(ifc.imem_req_valid), 32'd1);
            for (int k = 0; k < 20; k++) begin
                if (ifc.imem_req_valid !== 1'b1) break;
                check("req_addr", ifc.imem_addr, pc);
                @(negedge clk);
            end
            if (wait_pulse) begin
                ifc.next_pc       = 32'h1234_5670;
                ifc.next_pc_valid = 1'b1;
                @(negedge clk);
                ifc.next_pc_valid = 1'b0;
            end
        end else begin
            check("no_req_misaligned", 32'(ifc.imem_req_valid), 32'd0);
        end
        receive(hold);
        if (stall == 0 && !wait_pulse)
            check("latency", 32'(last_valid_cyc - c0), aligned ? 32'd3 : 32'd1);
        check("req_count", 32'(req_count - rc0), aligned ? 32'd1 : 32'd0);
        err_en = 1'b0;
    endtask

    initial begin
        int c0;
        int rc0;
        exp_t e;
        rst_n             = 1'b0;
        ifc.next_pc       = '0;
        ifc.next_pc_valid = 1'b0;
        ifc.inst_ready    = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_req_valid", 32'(ifc.imem_req_valid), 32'd1);
        check("rst_addr", ifc.imem_addr, RESET_PC);
        check("rst_inst_valid", 32'(ifc.inst_valid), 32'd0);
        check("rst_inst", ifc.inst, 32'd0);
        check("rst_inst_pc", ifc.inst_pc, 32'd0);
        check("rst_fault", 32'(ifc.fetch_fault), 32'd0);

        // first fetch after reset
        e.inst = 32'h0000_0413; e.pc = RESET_PC; e.fault = 1'b0;
        q.push_back(e);
        c0  = cyc;
        rc0 = req_count;
        rst_n = 1'b1;
        receive(0);
        check("first_latency", 32'(last_valid_cyc - c0), 32'd2);
        check("first_req_count", 32'(req_count - rc0), 32'd1);

        // stalled request, decoder back-pressure
        fetch(32'h8000_0004, 4, 3, 1'b0, 1'b0);
        // misaligned target
        fetch(32'h8000_0006, 0, 0, 1'b0, 1'b0);
        // bus error
        fetch(32'h8000_0010, 0, 0, 1'b1, 1'b0);
        @(negedge clk);
        check("idle_after_err", 32'(ifc.imem_req_valid), 32'd0);

        // reset while waiting for a response, stray response afterwards
        ifc.next_pc       = 32'h8000_0040;
        ifc.next_pc_valid = 1'b1;
        @(negedge clk);
        ifc.next_pc_valid = 1'b0;
        check("rw_req", 32'(ifc.imem_req_valid), 32'd1);
        @(negedge clk);
        check("rw_in_wait", 32'(ifc.imem_req_valid), 32'd0);
        rst_n = 1'b0;
        stall_cfg = 3;
        stall_gen++;
        repeat (2) @(negedge clk);
        check("rw_rst_req", 32'(ifc.imem_req_valid), 32'd1);
        check("rw_rst_addr", ifc.imem_addr, RESET_PC);
        check("rw_rst_valid", 32'(ifc.inst_valid), 32'd0);
        e.inst = mem_word(RESET_PC); e.pc = RESET_PC; e.fault = 1'b0;
        q.push_back(e);
        rc0 = req_count;
        rst_n = 1'b1;
        stray_gen++;
        @(negedge clk);
        check("rw_addr_after", ifc.imem_addr, RESET_PC);
        check("rw_still_req", 32'(ifc.imem_req_valid), 32'd1);
        receive(0);
        check("rw_req_count", 32'(req_count - rc0), 32'd1);

        // PC sequence, including a next_pc_valid pulse during WAIT
        fetch(32'h8000_0004, 0, 0, 1'b0, 1'b1);
        fetch(32'h8000_0100, 0, 1, 1'b0, 1'b0);
        fetch(32'hFFFF_FFFC, 0, 0, 1'b0, 1'b0);

        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
